// File: rtl/sc_mul_seq.sv
// Stochastic-computing multiplier: two round-robin requesters share one
// 16-cycle AND-stream engine whose ones-count is the scaled product.
module sc_mul_seq #(
    parameter int VALID_W = 5,
    parameter int RES_W   = 5,
    parameter int SEQ_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [VALID_W-1:0] req0_a,
    input  logic [VALID_W-1:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [VALID_W-1:0] req1_a,
    input  logic [VALID_W-1:0] req1_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [RES_W-1:0]   res_data,
    output logic               res_id,
    output logic               bit_out,
    output logic               busy
);

    localparam int IDX_W = $clog2(SEQ_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // Scrambled threshold order decorrelates stream A from the ramp on B.
    localparam logic [VALID_W-1:0] S1_TAB [SEQ_LEN] = '{
        VALID_W'(0),  VALID_W'(16), VALID_W'(24), VALID_W'(8),
        VALID_W'(12), VALID_W'(28), VALID_W'(20), VALID_W'(4),
        VALID_W'(6),  VALID_W'(22), VALID_W'(30), VALID_W'(14),
        VALID_W'(10), VALID_W'(26), VALID_W'(18), VALID_W'(2)
    };

    state_e             state_q, state_d;
    logic               ptr_q;
    logic               id_q;
    logic [VALID_W-1:0] a_q, b_q;
    logic [IDX_W-1:0]   idx_q;
    logic [RES_W-1:0]   acc_q;

    logic               idle, run, done;
    logic               gnt1;
    logic               accept;
    logic               last_idx;
    logic               stream_bit;
    logic [VALID_W-1:0] s2;

    assign idle = (state_q == S_IDLE);
    assign run  = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    // ptr_q holds the last granted id; on a tie the other one wins.
    assign gnt1   = req1_valid & (~req0_valid | ~ptr_q);
    assign accept = idle & (req0_valid | req1_valid);

    assign last_idx   = (idx_q == IDX_W'(SEQ_LEN - 1));
    assign s2         = VALID_W'({idx_q, 1'b0});
    assign stream_bit = (a_q > S1_TAB[idx_q]) & (b_q > s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN:  if (last_idx) state_d = S_DONE;
            S_DONE: if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = idle & req0_valid & ~gnt1;
        req1_ready = idle & gnt1;
        busy       = ~idle;
        bit_out    = run & stream_bit;
        res_valid  = done;
        res_data   = done ? acc_q : '0;
        res_id     = done & id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
            id_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            acc_q <= '0;
        end else if (accept) begin
            ptr_q <= gnt1;
            id_q  <= gnt1;
            a_q   <= gnt1 ? req1_a : req0_a;
            b_q   <= gnt1 ? req1_b : req0_b;
            idx_q <= '0;
            acc_q <= '0;
        end else if (run) begin
            acc_q <= acc_q + RES_W'(stream_bit);
            idx_q <= last_idx ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_sc_mul_seq.sv
// Randomized and directed checks of sc_mul_seq against a
// count-of-threshold-hits reference model.
module tb_sc_mul_seq;

    localparam int VW = 5;
    localparam int RW = 5;
    localparam int SL = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [VW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          res_valid, res_ready;
    logic [RW-1:0] res_data;
    logic          res_id, bit_out, busy;

    int checks = 0;
    int errors = 0;
    bit last_id;

    int S1 [SL] = '{0, 16, 24, 8, 12, 28, 20, 4,
                    6, 22, 30, 14, 10, 26, 18, 2};

    always #5 clk = ~clk;

    sc_mul_seq #(.VALID_W(VW), .RES_W(RW), .SEQ_LEN(SL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .bit_out    (bit_out),
        .busy       (busy)
    );

    function automatic bit ref_bit(input int a, input int b, input int i);
        return (a > S1[i]) && (b > 2 * i);
    endfunction

    function automatic int ref_count(input int a, input int b);
        int n = 0;
        for (int i = 0; i < SL; i++) n += int'(ref_bit(a, b, i));
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        req0_valid = 1'($urandom);
        req1_valid = 1'($urandom);
        req0_a = VW'($urandom);
        req0_b = VW'($urandom);
        req1_a = VW'($urandom);
        req1_b = VW'($urandom);
    endtask

    task automatic run_op(input bit v0, input bit v1,
                          input int a0, input int b0,
                          input int a1, input int b1,
                          input int stall);
        bit w;
        int a, b, exp;
        w = (v0 && v1) ? ~last_id : v1;
        a = w ? a1 : a0;
        b = w ? b1 : b0;
        exp = ref_count(a, b);
        req0_valid = v0;
        req1_valid = v1;
        req0_a = VW'(a0);
        req0_b = VW'(b0);
        req1_a = VW'(a1);
        req1_b = VW'(b1);
        res_ready = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("ready0", req0_ready, !w);
        chk("ready1", req1_ready, w);
        tick();
        for (int i = 0; i < SL; i++) begin
            scramble();
            #1;
            chk("run_busy", busy, 1);
            chk("run_resv", res_valid, 0);
            chk("run_bit", bit_out, ref_bit(a, b, i));
            chk("run_rdy", {req0_ready, req1_ready}, 0);
            tick();
        end
        for (int s = 0; s <= stall; s++) begin
            scramble();
            #1;
            chk("done_valid", res_valid, 1);
            chk("done_data", res_data, exp);
            chk("done_id", res_id, w);
            chk("done_rdy", {req0_ready, req1_ready}, 0);
            chk("done_bit", bit_out, 0);
            if (s < stall) tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ret_valid", res_valid, 0);
        chk("ret_busy", busy, 0);
        last_id = w;
    endtask

    initial begin
        int gr[$], ids[$], cyc[$], dat[$];
        int nres;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0;
        req0_b = '0;
        req1_a = '0;
        req1_b = '0;
        res_ready = 1'b0;
        last_id = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_id", res_id, 0);
        chk("rst_bit", bit_out, 0);
        chk("rst_rdy", {req0_ready, req1_ready}, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Both requesters always valid, consumer always ready.
        req0_valid = 1'b1;
        req0_a = 5'd31;
        req0_b = 5'd31;
        req1_valid = 1'b1;
        req1_a = 5'd16;
        req1_b = 5'd16;
        res_ready = 1'b1;
        nres = 0;
        for (int c = 0; c < 200 && nres < 4; c++) begin
            #1;
            if (req0_ready) gr.push_back(0);
            if (req1_ready) gr.push_back(1);
            if (res_valid) begin
                ids.push_back(int'(res_id));
                dat.push_back(int'(res_data));
                cyc.push_back(c);
                nres++;
            end
            if (nres < 4) tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        res_ready = 1'b0;
        chk("rr_results", nres, 4);
        if (nres == 4 && gr.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("rr_grant", gr[k], k % 2);
                chk("rr_id", ids[k], k % 2);
                chk("rr_data", dat[k], (k % 2) ? 4 : 16);
                if (k > 0) chk("rr_gap", cyc[k] - cyc[k-1], 18);
            end
        end else begin
            chk("rr_grants", gr.size(), 4);
        end
        last_id = 1'b1;

        run_op(1, 0, 31, 31, 0, 0, 0);
        run_op(0, 1, 0, 0, 16, 31, 0);
        run_op(0, 1, 0, 0, 31, 16, 0);
        run_op(0, 1, 0, 0, 16, 16, 0);
        run_op(0, 1, 0, 0, 0, 31, 0);
        run_op(1, 0, 16, 31, 0, 0, 5);
        run_op(1, 1, 20, 9, 7, 25, 1);
        run_op(1, 1, 11, 30, 29, 3, 0);

        for (int n = 0; n < 12; n++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            run_op(v0, v1, $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 3));
        end

        // Reset in the middle of a stream.
        req0_valid = 1'b1;
        req0_a = 5'd31;
        req0_b = 5'd20;
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_bit7", bit_out, ref_bit(31, 20, 7));
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_bit", bit_out, 0);
        chk("mr_busy", busy, 0);
        chk("mr_valid", res_valid, 0);
        chk("mr_data", res_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_hold", res_valid, 0);
        end
        rst_n = 1'b1;
        last_id = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mr_noresult", res_valid, 0);
        end
        run_op(1, 1, 24, 17, 5, 30, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
